// File: rtl/fifo_arb_pkg.sv
// Shared arbiter definitions: FSM encoding, beat counter width, pointer reset value.
// Pure definitions, no logic.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int BEAT_CNT_W = 8;

  // Pointer parks on the last requester so requester 0 wins first after reset.
  function automatic int rr_ptr_reset(input int num_req);
    return num_req - 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first set bit of req scanning upward from ptr+1 (mod N).
// Purely combinational, zero latency; no handshake of its own.
module rr_priority_select #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] off;
  logic [N-1:0]     rot;
  logic [IDX_W:0]   sum;
  logic             found;

  always_comb begin
    start = (ptr == IDX_W'(N - 1)) ? '0 : ptr + 1'b1;
    // Rotate so the highest-priority requester lands on bit 0.
    rot   = N'({req, req} >> start);
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    idx = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N)) : IDX_W'(sum);
    any = found;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter driving one FIFO write port; 1-cycle arbitration, beats pass through combinationally.
// Stalls the granted requester whenever the FIFO's registered depth leaves no usable slot.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_WIDTH   = $clog2(NUM_REQ),
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset_poweron,
  input  logic                          clear,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [ADDR_WIDTH-1:0]         fifo_depth,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic [BEAT_CNT_W-1:0]         beat_count
);

  localparam logic [ID_WIDTH-1:0]   RR_PTR_RST = ID_WIDTH'(rr_ptr_reset(NUM_REQ));
  localparam logic [ADDR_WIDTH-1:0] FULL_LVL   = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [BEAT_CNT_W-1:0] BURST_MAX  = BEAT_CNT_W'(MAX_BURST);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic                space_ok;
  logic                xfer;
  logic                end_burst;
  logic                win_any;
  logic [ID_WIDTH-1:0] win_idx;

  rr_priority_select #(
    .N (NUM_REQ)
  ) u_rr_sel (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (win_any),
    .idx (win_idx)
  );

  // One slot is always kept empty (empty is rp==wp); a same-cycle read is not credited.
  assign space_ok        = fifo_depth < FULL_LVL;
  assign grant_valid     = (state_q == GRANT);
  assign grant_id        = grant_id_q;
  assign beat_count      = beat_cnt_q;
  assign fifo_write_data = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    req_ready = '0;
    if (state_q == GRANT && space_ok) begin
      req_ready[grant_id_q] = 1'b1;
    end
    xfer       = req_valid[grant_id_q] && req_ready[grant_id_q];
    fifo_write = xfer;
    end_burst  = req_last[grant_id_q] || ((beat_cnt_q + 1'b1) == BURST_MAX);
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (clear) begin
      state_d    = IDLE;
      grant_id_d = '0;
      rr_ptr_d   = RR_PTR_RST;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any) begin
            grant_id_d = win_idx;
            beat_cnt_d = '0;
            state_d    = GRANT;
          end
        end
        GRANT: begin
          // A stalled or silent granted requester keeps the grant (packet lock).
          if (xfer) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (end_burst) begin
              rr_ptr_d = grant_id_q;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= RR_PTR_RST;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
